xcorr_ctrl: RTL
===============

Name: xcorr_ctrl

Overview:
- Frame sequencer for the XCORR datapath inside the mic subsystem.
- Gates paired mic samples into the correlator's series_x/series_y inputs and holds the correlator's start line.
- Counts the correlator's complete/result stream, tracks the peak correlation and reports the peak lag as signed lag_diff.
- Sits between the sign-extension stage and the XCORR top; produces the lag_diff routed to the top-level pad.

Parameters:
- W, 16, sample width (two's complement).
- N, 512, samples per frame fed to the correlator.
- MAX_LAG, 31, maximum lag magnitude; the correlator emits 2*MAX_LAG+1 results, ordered from lag -MAX_LAG to +MAX_LAG.
- RW, 32, correlator result width (signed).
- TIMEOUT, 4096, idle cycles tolerated in FLUSH/COLLECT before abort.

Ports:
- clk  in  1  system clock (60 MHz domain).
- rst  in  1  synchronous, active-high reset.
- en  in  1  level; while high, frames run back-to-back.
- smp_valid  in  1  one-cycle strobe, new sample pair available.
- smp_x  in  W  signed mic0 sample.
- smp_y  in  W  signed mic1 sample.
- xc_start  out  1  correlator hold; high = correlator held in init, low = running.
- xc_series_x  out  W  signed sample to correlator.
- xc_series_y  out  W  signed sample to correlator.
- xc_complete  in  1  correlator result strobe.
- xc_result  in  RW  signed correlator result, valid with xc_complete.
- lag_diff  out  6  signed peak lag, held until the next frame's update.
- peak_val  out  RW  signed peak correlation value.
- lag_valid  out  1  one-cycle pulse when lag_diff/peak_val update.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky abort flag; cleared by rst or the next LOAD entry.

Behaviour:
- Reset values: all outputs registered; reset drives xc_start=1 and everything else to 0; FSM to IDLE.
- IDLE:
  - xc_start=1, series outputs 0.
  - If en=1, go to LOAD the next cycle, with xc_start=0 from that cycle.
- LOAD:
  - Each smp_valid registers smp_x/smp_y onto the series outputs, one cycle latency, and increments smp_cnt.
  - Series outputs hold their value between strobes.
  - After the N-th strobe is accepted, go to FLUSH.
  - smp_valid outside LOAD is ignored.
- FLUSH/COLLECT:
  - Series outputs are 0.
  - FLUSH moves to COLLECT on the first xc_complete; that strobe is counted as result index 0.
- Result counting:
  - Each xc_complete increments res_idx from 0 to 2*MAX_LAG.
  - Index 0 loads best_val and best_idx unconditionally.
  - Later indices update only if xc_result > best_val (signed, strict), so ties keep the earliest (most negative) lag.
  - After index 2*MAX_LAG, go to DONE.
- DONE:
  - One cycle: lag_diff = best_idx - MAX_LAG (signed 6-bit), peak_val = best_val, lag_valid=1.
  - Then go to IDLE, where xc_start=1 for at least one cycle. With en still 1, LOAD follows (minimum gap of 1 cycle).
- Timeout:
  - wd_cnt counts cycles without xc_complete in FLUSH/COLLECT and resets on each strobe.
  - Reaching TIMEOUT sets err_timeout and returns to IDLE; lag_diff/peak_val keep old values and no lag_valid is issued.
- en dropping mid-frame: the frame completes; en is sampled only in IDLE.
- Extra xc_complete in IDLE/LOAD/DONE is ignored.
- rst mid-operation: immediate return to IDLE, counters cleared, xc_start=1 the following cycle.
- A simultaneous smp_valid on the N-th sample and an early xc_complete cannot occur (FLUSH starts afterwards); the complete is ignored.
- Widths:
  - smp_cnt is clog2(N+1) bits.
  - res_idx is clog2(2*MAX_LAG+1) bits.
  - The subtraction is done in 7 bits, then truncated to 6 bits; MAX_LAG ≤ 31 is required.

Decomposition:
- Shared package xcorr_pkg holds:
  - the state enum {IDLE, LOAD, FLUSH, COLLECT, DONE};
  - the parameters W, N, MAX_LAG, RW;
  - the localparam NRES = 2*MAX_LAG+1.
- One sub-module, xcorr_peak_track: running signed argmax with init/update/strobe inputs, outputting best_val and best_idx.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, en=0 -> xc_start=1, lag_diff=0, busy=0, lag_valid never pulses.
- Nominal frame:
  - Stimulus: en=1; 512 smp_valid strobes with x[i]=i; then 63 xc_complete strobes with a result peak of 1000 at index 40.
  - Required response: xc_series_x follows x[i] one cycle after each strobe; exactly one lag_valid with lag_diff=+9 and peak_val=1000.
- Tie and negative lag:
  - Stimulus: results of -5 everywhere except 700 at indices 2 and 50.
  - Required response: lag_diff=-29, peak_val=700.
- Back-to-back frames: en held 1 -> xc_start high for exactly 1 cycle between frames; the second frame's peak at index 31 gives lag_diff=0.
- Timeout: results stop after index 10 -> err_timeout=1 after 4096 cycles, FSM back to IDLE, lag_diff unchanged, no lag_valid.
- Reset mid-LOAD: rst pulsed after 200 samples -> xc_start=1 the next cycle, smp_cnt restarts, and the next frame needs a full 512 samples.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared types and sizing for the XCORR frame sequencer.
package xcorr_pkg;

  localparam int W       = 16;
  localparam int N       = 512;
  localparam int MAX_LAG = 31;
  localparam int RW      = 32;
  localparam int NRES    = 2 * MAX_LAG + 1;
  localparam int SCW     = $clog2(N + 1);
  localparam int RIW     = $clog2(NRES);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, COLLECT, DONE} state_t;

endpackage

// File: rtl/xcorr_peak_track.sv
// Running signed argmax over the correlator result stream.
module xcorr_peak_track
  import xcorr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe,
  input  logic                 init,
  input  logic [RIW-1:0]       idx,
  input  logic signed [RW-1:0] val,
  output logic signed [RW-1:0] best_val,
  output logic [RIW-1:0]       best_idx
);

  // Strict compare so a tie keeps the earliest (most negative) lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (strobe && (init || (val > best_val))) begin
      best_val <= val;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/xcorr_ctrl.sv
// Frame sequencer: feeds N sample pairs to the correlator, then reports the peak lag.
module xcorr_ctrl
  import xcorr_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 smp_valid,
  input  logic signed [W-1:0]  smp_x,
  input  logic signed [W-1:0]  smp_y,
  output logic                 xc_start,
  output logic signed [W-1:0]  xc_series_x,
  output logic signed [W-1:0]  xc_series_y,
  input  logic                 xc_complete,
  input  logic signed [RW-1:0] xc_result,
  output logic signed [5:0]    lag_diff,
  output logic signed [RW-1:0] peak_val,
  output logic                 lag_valid,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [SCW-1:0]        smp_cnt;
  logic [RIW-1:0]        res_idx;
  logic [WDW-1:0]        wd_cnt;
  logic                  trk_strobe;
  logic                  trk_init;
  logic signed [RW-1:0]  best_val;
  logic [RIW-1:0]        best_idx;
  logic [6:0]            lag_wide;

  assign trk_strobe = xc_complete && ((state == FLUSH) || (state == COLLECT));
  assign trk_init   = (state == FLUSH);
  // Widened to 7 bits so the offset subtraction cannot wrap before truncation.
  assign lag_wide   = 7'(best_idx) - 7'(MAX_LAG);

  xcorr_peak_track u_peak (
    .clk      (clk),
    .rst      (rst),
    .strobe   (trk_strobe),
    .init     (trk_init),
    .idx      (res_idx),
    .val      (xc_result),
    .best_val (best_val),
    .best_idx (best_idx)
  );

  always_ff @(posedge clk) begin
    lag_valid <= 1'b0;
    if (rst) begin
      state       <= IDLE;
      xc_start    <= 1'b1;
      xc_series_x <= '0;
      xc_series_y <= '0;
      lag_diff    <= '0;
      peak_val    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      smp_cnt     <= '0;
      res_idx     <= '0;
      wd_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          xc_series_x <= '0;
          xc_series_y <= '0;
          if (en) begin
            state       <= LOAD;
            xc_start    <= 1'b0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            smp_cnt     <= '0;
          end
        end
        LOAD: begin
          if (smp_valid) begin
            xc_series_x <= smp_x;
            xc_series_y <= smp_y;
            if (smp_cnt == SCW'(N - 1)) begin
              state   <= FLUSH;
              smp_cnt <= '0;
              res_idx <= '0;
              wd_cnt  <= '0;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end
        FLUSH, COLLECT: begin
          xc_series_x <= '0;
          xc_series_y <= '0;
          if (xc_complete) begin
            wd_cnt <= '0;
            if (res_idx == RIW'(NRES - 1)) begin
              state <= DONE;
            end else begin
              state   <= COLLECT;
              res_idx <= res_idx + 1'b1;
            end
          end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            xc_start    <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          lag_diff  <= $signed(lag_wide[5:0]);
          peak_val  <= best_val;
          lag_valid <= 1'b1;
          state     <= IDLE;
          xc_start  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          xc_start <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
